// File: rtl/fibonacci_lanes.sv
// Multi-lane Fibonacci-style term generator: LANES terms of t(n+2)=t(n)+t(n+1) per beat,
// valid/ready output, per-term carry tracking and optional stop-on-wrap truncation.
module fibonacci_lanes #(
  parameter int W            = 16,
  parameter int LANES        = 2,
  parameter int STOP_ON_WRAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W-1:0]       seed_a,
  input  logic [W-1:0]       seed_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_last,
  output logic               wrapped,
  output logic               busy
);

  localparam int N = LANES + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [W-1:0]   a_reg, b_reg;
  logic           aw_reg, bw_reg;
  logic           wrapped_reg;

  logic [N-1:0][W-1:0] lane_val;
  logic [N-1:0]        lane_wrap;
  logic [W:0]          lane_sum;
  logic [LANES-1:0]    keep_next;
  logic                emit_wrap;
  logic                seen;
  logic                run;
  logic                xfer;

  // Emitted lanes plus two lookahead terms that become the next a/b.
  always_comb begin
    lane_val     = '0;
    lane_wrap    = '0;
    lane_sum     = '0;
    lane_val[0]  = a_reg;
    lane_val[1]  = b_reg;
    lane_wrap[0] = aw_reg;
    lane_wrap[1] = bw_reg;
    for (int i = 2; i < N; i++) begin
      lane_sum     = {1'b0, lane_val[i-2]} + {1'b0, lane_val[i-1]};
      lane_val[i]  = lane_sum[W-1:0];
      lane_wrap[i] = lane_sum[W] | lane_wrap[i-2] | lane_wrap[i-1];
    end
  end

  // keep_next[i] is set only while no lane 0..i carries a wrap flag.
  always_comb begin
    keep_next = '0;
    seen      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      seen         = seen | lane_wrap[i];
      keep_next[i] = ~seen;
    end
    emit_wrap = seen;
  end

  assign run  = (state_reg == RUN);
  assign xfer = run && out_ready;

  assign out_valid = run;
  assign busy      = run;
  assign wrapped   = wrapped_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_out
      assign out_data[gi*W +: W] = run ? lane_val[gi] : '0;
    end
    if (STOP_ON_WRAP != 0) begin : g_stop
      assign out_keep = run ? keep_next : '0;
      assign out_last = run && emit_wrap;
    end else begin : g_wrap
      assign out_keep = run ? {LANES{1'b1}} : '0;
      assign out_last = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      aw_reg      <= 1'b0;
      bw_reg      <= 1'b0;
      wrapped_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg       <= seed_a;
            b_reg       <= seed_b;
            aw_reg      <= 1'b0;
            bw_reg      <= 1'b0;
            wrapped_reg <= 1'b0;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (xfer) begin
            if (STOP_ON_WRAP != 0 && emit_wrap) begin
              state_reg <= DONE;
            end else begin
              a_reg  <= lane_val[LANES];
              b_reg  <= lane_val[LANES+1];
              aw_reg <= lane_wrap[LANES];
              bw_reg <= lane_wrap[LANES+1];
              if (STOP_ON_WRAP == 0 && emit_wrap) wrapped_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (start) begin
            a_reg       <= seed_a;
            b_reg       <= seed_b;
            aw_reg      <= 1'b0;
            bw_reg      <= 1'b0;
            wrapped_reg <= 1'b0;
            state_reg   <= RUN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_lanes.sv
// Directed bench for fibonacci_lanes: stop mode with 2 and 3 lanes, wrap mode,
// backpressure, abort, reset and restart.
module tb_fibonacci_lanes;

  logic        clk;
  logic        rst;
  logic [15:0] seed_a, seed_b;

  logic        start0, abort0, ready0, valid0, last0, wrapped0, busy0;
  logic [31:0] data0;
  logic [1:0]  keep0;

  logic        start1, abort1, ready1, valid1, last1, wrapped1, busy1;
  logic [47:0] data1;
  logic [2:0]  keep1;

  logic        start2, abort2, ready2, valid2, last2, wrapped2, busy2;
  logic [31:0] data2;
  logic [1:0]  keep2;

  int    errors;
  int    checks;
  longint fib [0:40];

  fibonacci_lanes #(.W(16), .LANES(2), .STOP_ON_WRAP(1)) d0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .seed_a(seed_a), .seed_b(seed_b), .out_valid(valid0), .out_ready(ready0),
    .out_data(data0), .out_keep(keep0), .out_last(last0),
    .wrapped(wrapped0), .busy(busy0)
  );

  fibonacci_lanes #(.W(16), .LANES(3), .STOP_ON_WRAP(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .seed_a(seed_a), .seed_b(seed_b), .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .out_keep(keep1), .out_last(last1),
    .wrapped(wrapped1), .busy(busy1)
  );

  fibonacci_lanes #(.W(16), .LANES(2), .STOP_ON_WRAP(0)) d2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .seed_a(seed_a), .seed_b(seed_b), .out_valid(valid2), .out_ready(ready2),
    .out_data(data2), .out_keep(keep2), .out_last(last2),
    .wrapped(wrapped2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i <= 40; i++) fib[i] = fib[i-2] + fib[i-1];

    rst = 1'b1;
    seed_a = '0; seed_b = '0;
    start0 = 0; abort0 = 0; ready0 = 0;
    start1 = 0; abort1 = 0; ready1 = 0;
    start2 = 0; abort2 = 0; ready2 = 0;
    tick();
    tick();
    check("rst_valid", valid0, 0);
    check("rst_data", data0, 0);
    check("rst_keep", keep0, 0);
    check("rst_last", last0, 0);
    check("rst_wrapped", wrapped0, 0);
    check("rst_busy", busy0, 0);
    check("rst_valid_l3", valid1, 0);
    rst = 1'b0;
    tick();
    check("idle_valid", valid0, 0);

    // Stop mode, two lanes, with backpressure and an ignored start at beat (3,5).
    seed_a = 16'd0; seed_b = 16'd1; start0 = 1; ready0 = 1;
    tick();
    start0 = 0; seed_a = 16'd7; seed_b = 16'd7;
    for (int k = 0; k <= 12; k++) begin
      $display("d0 beat %0d data=%0d,%0d keep=%b last=%0b", k, data0[15:0], data0[31:16], keep0, last0);
      check("s2_valid", valid0, 1);
      check("s2_lane0", data0[15:0], fib[2*k] & 64'hffff);
      if (k < 12) check("s2_lane1", data0[31:16], fib[2*k+1] & 64'hffff);
      check("s2_keep", keep0, (k == 12) ? 2'b01 : 2'b11);
      check("s2_last", last0, (k == 12) ? 1 : 0);
      if (k == 2) begin
        ready0 = 0; start0 = 1; seed_a = 16'd5; seed_b = 16'd5;
        for (int j = 0; j < 5; j++) begin
          tick();
          start0 = 0;
          check("bp_valid", valid0, 1);
          check("bp_data", data0, 32'h0005_0003);
          check("bp_keep", keep0, 2'b11);
          check("bp_last", last0, 0);
        end
        ready0 = 1;
      end
      tick();
    end
    check("done_valid", valid0, 0);
    check("done_busy", busy0, 0);
    check("done_data", data0, 0);
    check("done_keep", keep0, 0);
    check("done_last", last0, 0);
    check("done_wrapped", wrapped0, 0);

    // Restart from DONE.
    seed_a = 16'd5; seed_b = 16'd5; start0 = 1;
    tick();
    start0 = 0;
    $display("d0 restart data=%0d,%0d keep=%b", data0[15:0], data0[31:16], keep0);
    check("restart_data", data0, 32'h0005_0005);
    check("restart_keep", keep0, 2'b11);
    check("restart_busy", busy0, 1);

    // Abort during beat (8,13).
    abort0 = 1;
    tick();
    abort0 = 0;
    check("abort1_valid", valid0, 0);
    seed_a = 16'd0; seed_b = 16'd1; start0 = 1;
    tick();
    start0 = 0;
    tick(); tick(); tick();
    check("pre_abort_data", data0, 32'h000D_0008);
    abort0 = 1;
    tick();
    abort0 = 0;
    check("abort_valid", valid0, 0);
    check("abort_busy", busy0, 0);
    start0 = 1;
    tick();
    start0 = 0;
    check("post_abort_data", data0, 32'h0001_0000);
    check("post_abort_keep", keep0, 2'b11);

    // Reset during beat (8,13).
    tick(); tick(); tick();
    check("pre_rst_data", data0, 32'h000D_0008);
    rst = 1;
    tick();
    rst = 0;
    check("midrst_valid", valid0, 0);
    check("midrst_data", data0, 0);
    start0 = 1;
    tick();
    start0 = 0;
    check("post_rst_data", data0, 32'h0001_0000);
    ready0 = 0;

    // Three lanes.
    seed_a = 16'd0; seed_b = 16'd1; start1 = 1; ready1 = 1;
    tick();
    start1 = 0;
    check("l3_b0", data1, {16'd1, 16'd1, 16'd0});
    check("l3_keep", keep1, 3'b111);
    check("l3_last", last1, 0);
    tick();
    check("l3_b1", data1, {16'd5, 16'd3, 16'd2});
    tick();
    check("l3_b2", data1, {16'd21, 16'd13, 16'd8});
    abort1 = 1;
    tick();
    abort1 = 0;
    check("l3_abort_valid", valid1, 0);
    seed_a = 16'd2; seed_b = 16'd1; start1 = 1;
    tick();
    start1 = 0;
    check("lucas_b0", data1, {16'd3, 16'd1, 16'd2});
    tick();
    check("lucas_b1", data1, {16'd11, 16'd7, 16'd4});
    ready1 = 0;

    // Wrap mode: continues modulo 2^16 and flags the carry.
    seed_a = 16'd0; seed_b = 16'd1; start2 = 1; ready2 = 1;
    tick();
    start2 = 0;
    for (int k = 0; k <= 13; k++) begin
      $display("d2 beat %0d data=%0d,%0d wrapped=%0b", k, data2[15:0], data2[31:16], wrapped2);
      check("wr_lane0", data2[15:0], fib[2*k] & 64'hffff);
      check("wr_lane1", data2[31:16], fib[2*k+1] & 64'hffff);
      check("wr_keep", keep2, 2'b11);
      check("wr_last", last2, 0);
      check("wr_wrapped", wrapped2, (k > 12) ? 1 : 0);
      tick();
    end
    check("wr_b12_data_ref", {16'd65346, 16'd55857}, fib[27] % 65536 * 65536 + fib[26] % 65536);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fibonacci_lanes.md
# fibonacci_lanes

Parametrised linear-recurrence term generator: emits `LANES` consecutive terms of t(n+2) = t(n) + t(n+1) per accepted beat, from run-time seeds. It has a valid/ready output handshake with backpressure, carry (wrap) detection, and a selectable stop-on-wrap mode that truncates the final beat with a lane mask. It is the general successor of the single- and double-rate Fibonacci counters in the sequential basics set, feeding downstream stream sinks and scoreboards.

## Interface
- `W`, default 16: term width in bits; 2..32.
- `LANES`, default 2: terms per beat; 1..8.
- `STOP_ON_WRAP`, default 1: 1 = end the sequence at the first term that overflows `W` bits; 0 = continue modulo 2^W.
- `clk` in, 1: single clock; all state changes on posedge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: load the seeds and begin; honoured only in IDLE or DONE.
- `abort` in, 1: return to IDLE; honoured in RUN and DONE.
- `seed_a` in, W: t0.
- `seed_b` in, W: t1.
- `out_valid` out, 1: the current beat is presented.
- `out_ready` in, 1: sink accepts; a beat transfers when `out_valid && out_ready`.
- `out_data` out, LANES*W: lane i (bits [i*W +: W]) = t(k+i).
- `out_keep` out, LANES: per-lane valid mask.
- `out_last` out, 1: final beat of the sequence (stop mode only).
- `wrapped` out, 1: sticky; some emitted term overflowed (wrap mode only).
- `busy` out, 1: state is RUN.

## Operation
- Registered state:
  - `a` = t(k), `b` = t(k+1), each with a wrap bit `aw` / `bw`;
  - FSM state IDLE / RUN / DONE;
  - `wrapped`.
- Lane values:
  - lane0 = a, lane1 = b;
  - lane i≥2 = lane(i-2) + lane(i-1), summed in W+1 bits and truncated to W.
  - Lane i's wrap flag = carry of its sum OR the wrap flag of either operand.
  - For LANES=1, lane1 is computed internally but not output.
- Next-state lookahead: a' = t(k+LANES) and b' = t(k+LANES+1), extended through the same chain with the same wrap-flag rule.
- Outputs are functions of registered state only. No combinational path from `out_ready`, `start` or `abort` to any output.
- FSM:
  - **IDLE**: `out_valid`=0. On `start`: a←seed_a, b←seed_b, aw=bw=0, `wrapped`←0, go to RUN.
  - **RUN**: `out_valid`=1.
    - On transfer in wrap mode: advance (a←a', b←b'). Set `wrapped` if any emitted lane's wrap flag is 1.
    - Stop mode: f = index of the lowest lane whose wrap flag is 1.
      - If f exists: `out_keep` = lanes 0..f-1 (may be all-zero when f=0) and `out_last`=1. On transfer, go to DONE.
      - Otherwise: `out_keep` all ones, `out_last`=0. On transfer, advance.
  - **DONE**: `out_valid`=0. `start` restarts exactly as from IDLE; `abort` goes to IDLE.
- Priority: `rst` > `abort` > `start` > transfer. `start` is ignored in RUN.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_keep` and `out_last` hold stable.

## Timing
- Reset (cycle after `rst` sampled high):
  - state IDLE;
  - `out_valid`, `out_last`, `wrapped`, `busy` = 0;
  - `out_data` = 0, `out_keep` = 0;
  - a, b, aw, bw = 0.
- `rst` mid-RUN discards the beat in flight; no partial transfer.
- Latency: `start` sampled at edge c → first beat (t0..t(LANES-1)) has `out_valid`=1 after edge c, i.e. during cycle c+1.
- Throughput: one beat per cycle while `out_ready`=1.
- `abort` sampled at edge c → `out_valid`=0 after edge c. A transfer coinciding with `abort` is not counted.
- In DONE, `out_keep` and `out_data` return to 0.
- Seeds are sampled only on the `start` edge; later changes to `seed_a`/`seed_b` have no effect.

## Test plan
- **W=16, LANES=2, seeds 0,1, ready=1**: beats (0,1), (1,2), (3,5), (8,13).
  - Beat 12 is (46368, 75025→masked) with keep=2'b01 and last=1.
  - State is DONE in the following cycle.
- **LANES=3, seeds 0,1**: beats (0,1,1), (2,3,5), (8,13,21), keep=3'b111.
  - Seeds 2,1 (Lucas): first beat (2,1,3), second (4,7,11).
- **STOP_ON_WRAP=0, W=16, LANES=2, seeds 0,1**:
  - beat 12 = (46368, 9489), `wrapped` rises after its transfer;
  - next beat = (55857, 65346);
  - `out_last` never asserts.
- **Backpressure**: hold `out_ready`=0 for 5 cycles on beat (3,5). Data, keep and last are stable throughout. Release → next transfer is (3,5), then (8,13).
- **abort / rst** asserted during beat (8,13) with `out_ready`=1:
  - `out_valid`=0 the next cycle and the beat is not consumed;
  - a new `start` with seeds 0,1 restarts at (0,1).
- **start in RUN is ignored; start in DONE restarts**: after a stop-mode end, `start` with seeds 5,5 gives first beat (5,5), keep=2'b11.
